snake_body_engine: RTL and testbench

- Parametrised snake state engine: owns head position, a MAX_LEN-deep body shift store, length, direction and game state.
- Detects wall and self collisions and answers per-pixel cell queries from the renderer with registered hit flags.
- Sits between the input decoder and the colour mux.
- Unlike the previous fixed 20-segment design, depth, grid size and wall mode are parameters.
- Adds reversal rejection, growth pending and a proper IDLE/RUN/DEAD sequence.

---
 rtl/snake_body_engine.sv | 212 +++++++++++++++++++++
 tb/tb_snake_body_engine.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_body_engine.sv
// Snake state engine: head, shifting body store, length, direction and IDLE/RUN/DEAD
// sequencing, with wall/self collision detection and registered per-cell render queries.
module snake_body_engine #(
    parameter int GRID_W   = 32,
    parameter int GRID_H   = 24,
    parameter int CW       = 6,
    parameter int MAX_LEN  = 64,
    parameter int LW       = 7,
    parameter int INIT_LEN = 3,
    parameter int START_X  = 16,
    parameter int START_Y  = 12,
    parameter bit WRAP     = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          tick,
    input  logic          dir_valid,
    input  logic [1:0]    dir,
    input  logic          grow,
    input  logic          q_valid,
    input  logic [CW-1:0] qx,
    input  logic [CW-1:0] qy,
    output logic [CW-1:0] head_x,
    output logic [CW-1:0] head_y,
    output logic [LW-1:0] length,
    output logic          running,
    output logic          game_over,
    output logic          len_full,
    output logic          hit_valid,
    output logic          hit_head,
    output logic          hit_body
);

    localparam int NSEG = MAX_LEN - 1;
    localparam int SW   = CW + 2;

    typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

    state_t        state;
    logic [1:0]    cur_dir;
    logic [1:0]    pend_dir;
    logic          grow_pend;
    logic [CW-1:0] seg_x [NSEG];
    logic [CW-1:0] seg_y [NSEG];

    logic signed [1:0]    dx, dy;
    logic signed [SW-1:0] sx, sy;
    logic [CW-1:0]        nx, ny;
    logic                 wall_hit, self_hit, collide, growing, step, q_head, q_body;
    logic [1:0]           dir_ref;
    logic [LW-1:0]        act_lim, self_lim;

    function automatic logic signed [1:0] delta_x(input logic [1:0] d);
        case (d)
            2'b00:   return 2'sb01;
            2'b10:   return 2'sb11;
            default: return 2'sb00;
        endcase
    endfunction

    function automatic logic signed [1:0] delta_y(input logic [1:0] d);
        case (d)
            2'b01:   return 2'sb11;
            2'b11:   return 2'sb01;
            default: return 2'sb00;
        endcase
    endfunction

    // One-step moves can only leave the grid by one cell, so wrapping is a two-sided clamp swap.
    function automatic logic [CW-1:0] wrap_coord(input logic signed [SW-1:0] v, input int lim);
        if (v < 0)
            return CW'(lim - 1);
        else if (v >= lim)
            return '0;
        else
            return v[CW-1:0];
    endfunction

    function automatic logic [CW-1:0] init_seg_x(input int i);
        return (i < INIT_LEN - 1) ? CW'(START_X - 1 - i) : '0;
    endfunction

    function automatic logic [CW-1:0] init_seg_y(input int i);
        return (i < INIT_LEN - 1) ? CW'(START_Y) : '0;
    endfunction

    assign len_full = (length == LW'(MAX_LEN));
    assign step     = (state == RUN) && tick;
    assign growing  = (grow_pend || grow) && !len_full;
    assign act_lim  = length - LW'(1);
    assign self_lim = growing ? act_lim : (length - LW'(2));
    // A dir arriving with a tick is judged against the direction that tick commits to.
    assign dir_ref  = step ? pend_dir : cur_dir;

    always_comb begin
        dx = delta_x(pend_dir);
        dy = delta_y(pend_dir);
        sx = $signed({2'b00, head_x}) + $signed({{CW{dx[1]}}, dx});
        sy = $signed({2'b00, head_y}) + $signed({{CW{dy[1]}}, dy});
        if (WRAP) begin
            nx       = wrap_coord(sx, GRID_W);
            ny       = wrap_coord(sy, GRID_H);
            wall_hit = 1'b0;
        end else begin
            nx       = sx[CW-1:0];
            ny       = sy[CW-1:0];
            wall_hit = (sx < 0) || (sx >= GRID_W) || (sy < 0) || (sy >= GRID_H);
        end
    end

    // The tail segment is excluded from self collision unless it stays put because of growth.
    always_comb begin
        self_hit = 1'b0;
        q_body   = 1'b0;
        for (int i = 0; i < NSEG; i++) begin
            if ((LW'(i) < self_lim) && (seg_x[i] == nx) && (seg_y[i] == ny))
                self_hit = 1'b1;
            if ((LW'(i) < act_lim) && (seg_x[i] == qx) && (seg_y[i] == qy))
                q_body = 1'b1;
        end
        q_head  = (qx == head_x) && (qy == head_y);
        collide = wall_hit || self_hit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            running   <= 1'b0;
            game_over <= 1'b0;
            head_x    <= CW'(START_X);
            head_y    <= CW'(START_Y);
            length    <= LW'(INIT_LEN);
            cur_dir   <= 2'b00;
            pend_dir  <= 2'b00;
            grow_pend <= 1'b0;
            hit_valid <= 1'b0;
            hit_head  <= 1'b0;
            hit_body  <= 1'b0;
            for (int i = 0; i < NSEG; i++) begin
                seg_x[i] <= init_seg_x(i);
                seg_y[i] <= init_seg_y(i);
            end
        end else begin
            hit_valid <= q_valid;
            if (q_valid) begin
                hit_head <= q_head;
                hit_body <= q_body;
            end
            if (dir_valid && ((dir ^ 2'b10) != dir_ref))
                pend_dir <= dir;
            if (grow)
                grow_pend <= 1'b1;

            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (tick) begin
                        cur_dir   <= pend_dir;
                        grow_pend <= 1'b0;
                        if (collide) begin
                            state     <= DEAD;
                            running   <= 1'b0;
                            game_over <= 1'b1;
                        end else begin
                            head_x   <= nx;
                            head_y   <= ny;
                            seg_x[0] <= head_x;
                            seg_y[0] <= head_y;
                            for (int i = 1; i < NSEG; i++) begin
                                seg_x[i] <= seg_x[i-1];
                                seg_y[i] <= seg_y[i-1];
                            end
                            if (growing)
                                length <= length + LW'(1);
                        end
                    end
                end
                DEAD: begin
                    if (start) begin
                        state     <= IDLE;
                        running   <= 1'b0;
                        game_over <= 1'b0;
                        head_x    <= CW'(START_X);
                        head_y    <= CW'(START_Y);
                        length    <= LW'(INIT_LEN);
                        cur_dir   <= 2'b00;
                        pend_dir  <= 2'b00;
                        grow_pend <= 1'b0;
                        hit_valid <= 1'b0;
                        hit_head  <= 1'b0;
                        hit_body  <= 1'b0;
                        for (int i = 0; i < NSEG; i++) begin
                            seg_x[i] <= init_seg_x(i);
                            seg_y[i] <= init_seg_y(i);
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_body_engine.sv
// Bench for snake_body_engine: default, wrap-around and MAX_LEN=4 builds share one stimulus;
// render queries are scored through an expected-result queue drained by a monitor.
module tb_snake_body_engine;
    localparam int CW = 6;
    localparam int LW = 7;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0, tick = 1'b0, dir_valid = 1'b0;
    logic grow = 1'b0, q_valid = 1'b0;
    logic [1:0] dir = 2'b00;
    logic [CW-1:0] qx = '0, qy = '0;

    logic [CW-1:0] head_x, head_y;
    logic [LW-1:0] length;
    logic running, game_over, len_full, hit_valid, hit_head, hit_body;

    logic [CW-1:0] w_head_x, w_head_y;
    logic [LW-1:0] w_length;
    logic w_running, w_game_over, w_len_full, w_hit_valid, w_hit_head, w_hit_body;

    logic [CW-1:0] m_head_x, m_head_y;
    logic [2:0]    m_length;
    logic m_running, m_game_over, m_len_full, m_hit_valid, m_hit_head, m_hit_body;

    int checks = 0;
    int failures = 0;
    logic [1:0] sb[$];

    always #5 clk = ~clk;

    snake_body_engine dut (
        .clk(clk), .rst(rst), .start(start), .tick(tick), .dir_valid(dir_valid), .dir(dir),
        .grow(grow), .q_valid(q_valid), .qx(qx), .qy(qy), .head_x(head_x), .head_y(head_y),
        .length(length), .running(running), .game_over(game_over), .len_full(len_full),
        .hit_valid(hit_valid), .hit_head(hit_head), .hit_body(hit_body));

    snake_body_engine #(.WRAP(1'b1)) dut_w (
        .clk(clk), .rst(rst), .start(start), .tick(tick), .dir_valid(dir_valid), .dir(dir),
        .grow(grow), .q_valid(q_valid), .qx(qx), .qy(qy), .head_x(w_head_x), .head_y(w_head_y),
        .length(w_length), .running(w_running), .game_over(w_game_over), .len_full(w_len_full),
        .hit_valid(w_hit_valid), .hit_head(w_hit_head), .hit_body(w_hit_body));

    snake_body_engine #(.MAX_LEN(4), .LW(3)) dut_m (
        .clk(clk), .rst(rst), .start(start), .tick(tick), .dir_valid(dir_valid), .dir(dir),
        .grow(grow), .q_valid(q_valid), .qx(qx), .qy(qy), .head_x(m_head_x), .head_y(m_head_y),
        .length(m_length), .running(m_running), .game_over(m_game_over), .len_full(m_len_full),
        .hit_valid(m_hit_valid), .hit_head(m_hit_head), .hit_body(m_hit_body));

    // Query scoreboard consumer: every hit_valid must match the oldest outstanding query.
    always @(negedge clk) begin
        logic [1:0] e;
        if (hit_valid) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL query_unexpected got head/body=%b required=no response", {hit_head, hit_body});
            end else begin
                e = sb.pop_front();
                if ({hit_head, hit_body} !== e) begin
                    failures++;
                    $display("FAIL query got head/body=%b required=%b", {hit_head, hit_body}, e);
                end
            end
        end
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0; start = 1'b0; tick = 1'b0; dir_valid = 1'b0; grow = 1'b0; q_valid = 1'b0;
        repeat (2) cyc();
        rst = 1'b1;
        cyc();
    endtask

    task automatic pulse_start;
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic step(input logic g);
        tick = 1'b1; grow = g; cyc(); tick = 1'b0; grow = 1'b0;
    endtask

    task automatic set_dir(input logic [1:0] d);
        dir_valid = 1'b1; dir = d; cyc(); dir_valid = 1'b0;
    endtask

    task automatic query(input logic [CW-1:0] x, input logic [CW-1:0] y, input logic eh, input logic eb);
        q_valid = 1'b1; qx = x; qy = y;
        sb.push_back({eh, eb});
        cyc();
        q_valid = 1'b0;
        cyc();
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if ({head_x, head_y} !== {6'd16, 6'd12}) begin
            failures++; $display("FAIL reset_head got (%0d,%0d) required (16,12)", head_x, head_y);
        end
        checks++;
        if (length !== 7'd3) begin
            failures++; $display("FAIL reset_length got %0d required 3", length);
        end
        checks++;
        if ({running, game_over, len_full} !== 3'b000) begin
            failures++; $display("FAIL reset_flags got run/over/full=%b required 000", {running, game_over, len_full});
        end
        checks++;
        if ({hit_valid, hit_head, hit_body} !== 3'b000) begin
            failures++; $display("FAIL reset_hits got %b required 000", {hit_valid, hit_head, hit_body});
        end
        query(6'd15, 6'd12, 1'b0, 1'b1);
        query(6'd14, 6'd12, 1'b0, 1'b1);
        query(6'd13, 6'd12, 1'b0, 1'b0);
        query(6'd0, 6'd0, 1'b0, 1'b0);
        query(6'd16, 6'd12, 1'b1, 1'b0);
        cyc();
        checks++;
        if ({hit_valid, hit_head, hit_body} !== 3'b010) begin
            failures++; $display("FAIL hit_hold got %b required 010", {hit_valid, hit_head, hit_body});
        end
    endtask

    task automatic test_run;
        do_reset();
        step(1'b0);
        checks++;
        if (head_x !== 6'd16 || running !== 1'b0) begin
            failures++; $display("FAIL idle_tick got x=%0d run=%b required x=16 run=0", head_x, running);
        end
        pulse_start();
        checks++;
        if (running !== 1'b1) begin
            failures++; $display("FAIL start_run got %b required 1", running);
        end
        for (int k = 1; k <= 3; k++) begin
            step(1'b0);
            checks++;
            if (head_x !== CW'(16 + k)) begin
                failures++; $display("FAIL run_step%0d got x=%0d required %0d", k, head_x, 16 + k);
            end
        end
        checks++;
        if ({head_y, length} !== {6'd12, 7'd3}) begin
            failures++; $display("FAIL run_state got y=%0d len=%0d required y=12 len=3", head_y, length);
        end
        pulse_start();
        checks++;
        if (running !== 1'b1 || head_x !== 6'd19) begin
            failures++; $display("FAIL start_in_run got run=%b x=%0d required run=1 x=19", running, head_x);
        end
        query(6'd18, 6'd12, 1'b0, 1'b1);
        query(6'd17, 6'd12, 1'b0, 1'b1);
        query(6'd16, 6'd12, 1'b0, 1'b0);
        // query and tick together: answer reflects the pre-step head
        q_valid = 1'b1; qx = 6'd19; qy = 6'd12; tick = 1'b1;
        sb.push_back(2'b10);
        cyc();
        q_valid = 1'b0; tick = 1'b0;
        cyc();
        checks++;
        if (head_x !== 6'd20) begin
            failures++; $display("FAIL query_tick_step got x=%0d required 20", head_x);
        end
    endtask

    task automatic test_direction;
        do_reset();
        pulse_start();
        set_dir(2'b10);
        step(1'b0);
        checks++;
        if ({head_x, head_y} !== {6'd17, 6'd12}) begin
            failures++; $display("FAIL reverse_reject got (%0d,%0d) required (17,12)", head_x, head_y);
        end
        set_dir(2'b01);
        step(1'b0);
        checks++;
        if ({head_x, head_y} !== {6'd17, 6'd11}) begin
            failures++; $display("FAIL turn_up got (%0d,%0d) required (17,11)", head_x, head_y);
        end
        set_dir(2'b11);
        set_dir(2'b10);
        step(1'b0);
        checks++;
        if ({head_x, head_y} !== {6'd16, 6'd11}) begin
            failures++; $display("FAIL last_dir_wins got (%0d,%0d) required (16,11)", head_x, head_y);
        end
        tick = 1'b1; dir_valid = 1'b1; dir = 2'b01;
        cyc();
        tick = 1'b0; dir_valid = 1'b0;
        checks++;
        if ({head_x, head_y} !== {6'd15, 6'd11}) begin
            failures++; $display("FAIL dir_with_tick got (%0d,%0d) required (15,11)", head_x, head_y);
        end
        step(1'b0);
        checks++;
        if ({head_x, head_y} !== {6'd15, 6'd10}) begin
            failures++; $display("FAIL dir_next_tick got (%0d,%0d) required (15,10)", head_x, head_y);
        end
    endtask

    task automatic test_grow;
        do_reset();
        pulse_start();
        step(1'b1);
        checks++;
        if (length !== 7'd4 || head_x !== 6'd17) begin
            failures++; $display("FAIL grow_with_tick got len=%0d x=%0d required len=4 x=17", length, head_x);
        end
        query(6'd14, 6'd12, 1'b0, 1'b1);
        query(6'd13, 6'd12, 1'b0, 1'b0);
        step(1'b0);
        checks++;
        if (length !== 7'd4) begin
            failures++; $display("FAIL grow_cleared got len=%0d required 4", length);
        end
        grow = 1'b1; cyc(); grow = 1'b0;
        cyc();
        step(1'b0);
        checks++;
        if (length !== 7'd5 || head_x !== 6'd19) begin
            failures++; $display("FAIL grow_pending got len=%0d x=%0d required len=5 x=19", length, head_x);
        end
    endtask

    task automatic test_wall;
        do_reset();
        pulse_start();
        repeat (15) step(1'b0);
        checks++;
        if (head_x !== 6'd31 || w_head_x !== 6'd31) begin
            failures++; $display("FAIL wall_approach got x=%0d wx=%0d required 31", head_x, w_head_x);
        end
        step(1'b0);
        checks++;
        if ({game_over, running, head_x} !== {1'b1, 1'b0, 6'd31}) begin
            failures++; $display("FAIL wall_right got over=%b run=%b x=%0d required 1,0,31", game_over, running, head_x);
        end
        checks++;
        if ({w_game_over, w_running, w_head_x} !== {1'b0, 1'b1, 6'd0}) begin
            failures++; $display("FAIL wrap_right got over=%b run=%b x=%0d required 0,1,0", w_game_over, w_running, w_head_x);
        end
        step(1'b0);
        checks++;
        if (head_x !== 6'd31 || game_over !== 1'b1) begin
            failures++; $display("FAIL dead_tick got x=%0d over=%b required 31,1", head_x, game_over);
        end
        do_reset();
        pulse_start();
        set_dir(2'b01);
        repeat (12) step(1'b0);
        checks++;
        if (head_y !== 6'd0 || w_head_y !== 6'd0) begin
            failures++; $display("FAIL top_approach got y=%0d wy=%0d required 0", head_y, w_head_y);
        end
        step(1'b0);
        checks++;
        if ({game_over, head_y} !== {1'b1, 6'd0}) begin
            failures++; $display("FAIL wall_top got over=%b y=%0d required 1,0", game_over, head_y);
        end
        checks++;
        if ({w_game_over, w_head_y} !== {1'b0, 6'd23}) begin
            failures++; $display("FAIL wrap_top got over=%b y=%0d required 0,23", w_game_over, w_head_y);
        end
    endtask

    task automatic test_self;
        do_reset();
        pulse_start();
        step(1'b1);
        step(1'b1);
        set_dir(2'b01); step(1'b0);
        set_dir(2'b10); step(1'b0);
        checks++;
        if ({head_x, head_y, length} !== {6'd17, 6'd11, 7'd5}) begin
            failures++; $display("FAIL curl_setup got (%0d,%0d) len=%0d required (17,11) len=5", head_x, head_y, length);
        end
        set_dir(2'b11); step(1'b0);
        checks++;
        if ({game_over, head_x, head_y, length} !== {1'b1, 6'd17, 6'd11, 7'd5}) begin
            failures++; $display("FAIL self_hit got over=%b (%0d,%0d) len=%0d required 1 (17,11) 5", game_over, head_x, head_y, length);
        end
        do_reset();
        pulse_start();
        step(1'b1);
        set_dir(2'b01); step(1'b0);
        set_dir(2'b10); step(1'b0);
        set_dir(2'b11); step(1'b0);
        checks++;
        if ({running, game_over, head_x, head_y} !== {1'b1, 1'b0, 6'd16, 6'd12}) begin
            failures++; $display("FAIL tail_chase got run=%b over=%b (%0d,%0d) required 1,0 (16,12)", running, game_over, head_x, head_y);
        end
        query(6'd16, 6'd11, 1'b0, 1'b1);
        query(6'd17, 6'd12, 1'b0, 1'b1);
        query(6'd15, 6'd12, 1'b0, 1'b0);
        do_reset();
        pulse_start();
        step(1'b1);
        set_dir(2'b01); step(1'b0);
        set_dir(2'b10); step(1'b0);
        set_dir(2'b11); step(1'b1);
        checks++;
        if ({game_over, head_x, head_y, length} !== {1'b1, 6'd16, 6'd11, 7'd4}) begin
            failures++; $display("FAIL tail_grow got over=%b (%0d,%0d) len=%0d required 1 (16,11) 4", game_over, head_x, head_y, length);
        end
    endtask

    task automatic test_maxlen;
        int n;
        do_reset();
        pulse_start();
        step(1'b1);
        checks++;
        if ({m_length, m_len_full} !== {3'd4, 1'b1}) begin
            failures++; $display("FAIL max_reach got len=%0d full=%b required 4,1", m_length, m_len_full);
        end
        step(1'b1);
        checks++;
        if ({m_length, m_len_full, m_head_x} !== {3'd4, 1'b1, 6'd18}) begin
            failures++; $display("FAIL max_hold got len=%0d full=%b x=%0d required 4,1,18", m_length, m_len_full, m_head_x);
        end
        n = 0;
        while (!m_game_over && n < 40) begin
            step(1'b0);
            n++;
        end
        checks++;
        if (m_game_over !== 1'b1 || n !== 14) begin
            failures++; $display("FAIL max_wall got over=%b after %0d ticks required 1 after 14", m_game_over, n);
        end
        pulse_start();
        checks++;
        if ({m_running, m_game_over, m_len_full, m_length} !== {1'b0, 1'b0, 1'b0, 3'd3}) begin
            failures++; $display("FAIL restart_flags got run/over/full=%b len=%0d required 000 len=3", {m_running, m_game_over, m_len_full}, m_length);
        end
        checks++;
        if ({m_head_x, m_head_y} !== {6'd16, 6'd12}) begin
            failures++; $display("FAIL restart_head got (%0d,%0d) required (16,12)", m_head_x, m_head_y);
        end
        pulse_start();
        checks++;
        if (m_running !== 1'b1) begin
            failures++; $display("FAIL restart_run got %b required 1", m_running);
        end
    endtask

    task automatic test_abort;
        do_reset();
        pulse_start();
        step(1'b0);
        tick = 1'b1;
        #3 rst = 1'b0;
        #1;
        checks++;
        if ({head_x, length, running} !== {6'd16, 7'd3, 1'b0}) begin
            failures++; $display("FAIL async_reset got x=%0d len=%0d run=%b required 16,3,0", head_x, length, running);
        end
        tick = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        checks++;
        if ({head_x, running} !== {6'd16, 1'b0}) begin
            failures++; $display("FAIL abort_after got x=%0d run=%b required 16,0", head_x, running);
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_direction();
        test_grow();
        test_wall();
        test_self();
        test_maxlen();
        test_abort();
        repeat (3) cyc();
        checks++;
        if (sb.size() != 0) begin
            failures++; $display("FAIL query_drain got %0d outstanding required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
